line_buffer_feeder: RTL
=======================

# line_buffer_feeder

Producer side of the 7×7 window. Takes a raster pixel stream, stores the previous MASK_WIDTH-1 image rows in line buffers and emits one vertical column of MASK_WIDTH pixels per beat into the window-mask block. Performs vertical mirror-without-duplication at the top and bottom image borders. Generates the horizontal border selects (`sel_left_col`, `sel_right_col`) that the window-mask uses for left/right mirroring.

## Interface
- PIX_BIT, 8, bits per pixel
- MASK_WIDTH, 7, window size; fixed at 7 because the mirror muxes are hard-wired
- IMG_WIDTH, 640, pixels per row; must be ≥ MASK_WIDTH
- IMG_HEIGHT, 480, rows per frame; must be ≥ MASK_WIDTH
- CNT_BIT, 10, width of the row and column counters; must hold IMG_WIDTH+2 and IMG_HEIGHT+2

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  synchronous, active-high
- pix_in_valid  in  1  pixel offered
- pix_in  in  PIX_BIT  raster pixel, row-major, top-left first
- pix_in_ready  out  1  feeder accepts the pixel this cycle
- col_valid  out  1  column beat present on outputs
- sngl_col_masked_pixs_out  out  PIX_BIT*MASK_WIDTH  column pixels
  - slice s = bits [PIX_BIT*(s+1)-1 : PIX_BIT*s]
  - s=0 is the newest row, s=6 the oldest
- sel_right_col  out  2  0 = normal; 1/2/3 = 1st/2nd/3rd right-flush beat
- sel_left_col  out  1  high on the beat presenting column index 3 of a row
- center_valid  out  1  window-mask output (one cycle after a beat) is centred on a real pixel
- frame_done  out  1  one-cycle pulse after the last beat of a frame

## Operation
- **Beat.**
  - A beat is an accepted input pixel (pix_in_valid & pix_in_ready), or a self-generated flush cycle (pix_in_ready = 0).
  - Column counter c runs 0..IMG_WIDTH+2. Virtual row counter r runs 0..IMG_HEIGHT+2.
- **Line buffers.**
  - Buffers B1..B6 form a shift chain; Bk holds row r-k.
  - On each beat with c < IMG_WIDTH:
    - every buffer is read at address c;
    - B1 is written with slice 0;
    - Bk+1 is written with the old Bk value.
  - Beats with c ≥ IMG_WIDTH do not touch the buffers.
- **FSM states.**
  - FILL: rows 0..2. Accept pixels and write the buffers; col_valid = 0.
  - RUN: rows 3..IMG_HEIGHT-1. Accept pixels; col_valid on every beat.
  - ROW_FLUSH: after c = IMG_WIDTH-1 in RUN or FRAME_FLUSH.
    - 3 beats, c = IMG_WIDTH..+2, pix_in_ready = 0, data slices = 0.
    - sel_right_col = 1, 2, 3 on these beats.
    - Then c = 0, r++, and return to RUN or FRAME_FLUSH. After virtual row IMG_HEIGHT+2, go to FILL, pulse frame_done and clear r.
  - FRAME_FLUSH: virtual rows IMG_HEIGHT..IMG_HEIGHT+2. pix_in_ready = 0; one beat per cycle.
- **Slice sources** (default: s0 = pix_in, sk = Bk):
  - r=3: s4=B2, s5=B1, s6=pix_in
  - r=4: s5=B3, s6=B2
  - r=5: s6=B4
  - Virtual rows IMG_HEIGHT, +1, +2: s0 = B2, B4, B6 respectively. s0 is also what is written into B1.
- **Horizontal selects.**
  - sel_left_col = 1 on beats with c = 3.
  - center_valid = 1 one cycle after beats with 3 ≤ c ≤ IMG_WIDTH+2. This gives IMG_WIDTH per output row and IMG_HEIGHT output rows per frame.
- **Back-to-back frames.** FILL of the next frame accepts pixels the cycle after frame_done; no idle gap.
- **Reset.**
  - Mid-frame reset abandons the frame: state = FILL, r = c = 0.
  - Line buffer contents are not cleared.

## Timing
- All outputs are registered and valid the cycle after the beat.
- Reset values: col_valid, sel_left_col, center_valid and frame_done are 0; sel_right_col is 0; data is 0.
- pix_in_ready after reset is 1.
- pix_in_ready is combinational from state only. It never depends on pix_in_valid.
- Input stalls (pix_in_valid = 0 in FILL/RUN) produce no beat: col_valid = 0 and counters hold.
- Flush beats occur every cycle with no stall.
- Per frame: IMG_HEIGHT·(IMG_WIDTH+3) column beats.
- First col_valid: one cycle after the first pixel of row 3.

## Structure
- Shared package: PIX_BIT, MASK_WIDTH, HALF = (MASK_WIDTH-1)/2, the FSM state encoding, and the sel_right_col codes.
- Sub-module `line_buffer`:
  - depth IMG_WIDTH × PIX_BIT circular RAM;
  - asynchronous read, write on enable, read-before-write at the same address.
- Six `line_buffer` instances sit in the chain. FSM, counters and mirror muxes are in the top module.

## Test plan
- Ramp image 8×8, pixel = 16·row+col, continuous valid. Required response:
  - first beat at row 3, c=0, slices = {0x30,0x20,0x10,0x00,0x10,0x20,0x30};
  - 8·11 = 88 beats total; frame_done one cycle after the last beat.
- Same image, check the row-end beats of row 4. Required response:
  - three flush beats with sel_right_col = 1, 2, 3;
  - pix_in_ready = 0 during them;
  - sel_left_col = 1 exactly at c=3.
- Bottom border, 8×8: virtual row 8, c=2 gives slices {0x62,0x72,0x62,0x52,0x42,0x32,0x22}.
- Random pix_in_valid gaps (50%). Required response: beat contents are identical to the continuous run; no beats while valid is low in RUN.
- Reset asserted mid-RUN at row 5. Required response:
  - next cycle col_valid = 0 and pix_in_ready = 1;
  - a fresh frame produces correct first beats.
- Two back-to-back frames, second frame inverted. Required response:
  - no gap between frames;
  - second frame's first beat uses only second-frame data.

Source files
------------

// File: rtl/line_buffer_feeder_pkg.sv
// Shared constants for the 7x7 window producer: pixel/window sizes, FSM encoding
// and the right-border flush select codes.
package line_buffer_feeder_pkg;

  localparam int PIX_BIT    = 8;
  localparam int MASK_WIDTH = 7;
  localparam int HALF       = (MASK_WIDTH - 1) / 2;

  typedef enum logic [1:0] {
    ST_FILL        = 2'd0,
    ST_RUN         = 2'd1,
    ST_ROW_FLUSH   = 2'd2,
    ST_FRAME_FLUSH = 2'd3
  } state_t;

  localparam logic [1:0] SEL_NORMAL = 2'd0;
  localparam logic [1:0] SEL_FLUSH1 = 2'd1;
  localparam logic [1:0] SEL_FLUSH2 = 2'd2;
  localparam logic [1:0] SEL_FLUSH3 = 2'd3;

endpackage

// File: rtl/line_buffer_feeder_line_buffer.sv
// One image row of pixel storage: asynchronous read, synchronous write, so a
// read and write at the same address in one beat returns the previous row.
module line_buffer
  import line_buffer_feeder_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int AW    = 10
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      addr,
  input  logic [PIX_BIT-1:0] wr_data,
  output logic [PIX_BIT-1:0] rd_data
);

  logic [PIX_BIT-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/line_buffer_feeder.sv
// Raster-to-column feeder for the 7x7 window: six chained row buffers, vertical
// border mirroring and horizontal border selects for the downstream window mask.
//
// state          | meaning
// ST_FILL        | rows 0..2, buffers filling, no column output
// ST_RUN         | rows 3..IMG_HEIGHT-1, one column per accepted pixel
// ST_ROW_FLUSH   | 3 self-timed beats past the row end for right mirroring
// ST_FRAME_FLUSH | virtual rows below the image, self-timed, bottom mirroring
module line_buffer_feeder
  import line_buffer_feeder_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int CNT_BIT    = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pix_in_valid,
  input  logic [PIX_BIT-1:0]            pix_in,
  output logic                          pix_in_ready,
  output logic                          col_valid,
  output logic [PIX_BIT*MASK_WIDTH-1:0] sngl_col_masked_pixs_out,
  output logic [1:0]                    sel_right_col,
  output logic                          sel_left_col,
  output logic                          center_valid,
  output logic                          frame_done
);

  localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

  localparam logic [CNT_BIT-1:0] ONE         = CNT_BIT'(1);
  localparam logic [CNT_BIT-1:0] C_LAST_PIX  = CNT_BIT'(IMG_WIDTH - 1);
  localparam logic [CNT_BIT-1:0] C_FLUSH1    = CNT_BIT'(IMG_WIDTH);
  localparam logic [CNT_BIT-1:0] C_FLUSH2    = CNT_BIT'(IMG_WIDTH + 1);
  localparam logic [CNT_BIT-1:0] C_LAST      = CNT_BIT'(IMG_WIDTH + 2);
  localparam logic [CNT_BIT-1:0] C_LEFT      = CNT_BIT'(HALF);
  localparam logic [CNT_BIT-1:0] R_LAST_FILL = CNT_BIT'(HALF - 1);
  localparam logic [CNT_BIT-1:0] R_TOP0      = CNT_BIT'(HALF);
  localparam logic [CNT_BIT-1:0] R_TOP1      = CNT_BIT'(HALF + 1);
  localparam logic [CNT_BIT-1:0] R_TOP2      = CNT_BIT'(HALF + 2);
  localparam logic [CNT_BIT-1:0] R_LAST_RUN  = CNT_BIT'(IMG_HEIGHT - 1);
  localparam logic [CNT_BIT-1:0] R_BOT0      = CNT_BIT'(IMG_HEIGHT);
  localparam logic [CNT_BIT-1:0] R_BOT1      = CNT_BIT'(IMG_HEIGHT + 1);
  localparam logic [CNT_BIT-1:0] R_LAST      = CNT_BIT'(IMG_HEIGHT + 2);

  state_t             state, state_nxt;
  logic [CNT_BIT-1:0] col_cnt, row_cnt, col_nxt, row_nxt;
  logic               beat, buf_we, in_flush, show_col, frame_end;
  logic [1:0]         sel_code;
  logic [PIX_BIT-1:0] lb_rd   [MASK_WIDTH-1];
  logic [PIX_BIT-1:0] col_pix [MASK_WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_FILL;
      col_cnt <= '0;
      row_cnt <= '0;
    end else begin
      state   <= state_nxt;
      col_cnt <= col_nxt;
      row_cnt <= row_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    col_nxt   = col_cnt;
    row_nxt   = row_cnt;
    frame_end = 1'b0;
    if (beat) begin
      col_nxt = col_cnt + ONE;
      unique case (state)
        ST_FILL: begin
          if (col_cnt == C_LAST_PIX) begin
            col_nxt = '0;
            row_nxt = row_cnt + ONE;
            if (row_cnt == R_LAST_FILL) state_nxt = ST_RUN;
          end
        end
        ST_RUN, ST_FRAME_FLUSH: begin
          if (col_cnt == C_LAST_PIX) state_nxt = ST_ROW_FLUSH;
        end
        ST_ROW_FLUSH: begin
          if (col_cnt == C_LAST) begin
            col_nxt = '0;
            if (row_cnt == R_LAST) begin
              row_nxt   = '0;
              state_nxt = ST_FILL;
              frame_end = 1'b1;
            end else begin
              row_nxt   = row_cnt + ONE;
              state_nxt = (row_cnt >= R_LAST_RUN) ? ST_FRAME_FLUSH : ST_RUN;
            end
          end
        end
        default: state_nxt = ST_FILL;
      endcase
    end
  end

  always_comb begin
    pix_in_ready = (state == ST_FILL) || (state == ST_RUN);
    in_flush     = (state == ST_ROW_FLUSH);
    show_col     = (state != ST_FILL);
    beat         = pix_in_ready ? pix_in_valid : 1'b1;
    buf_we       = beat && !in_flush;
    if (col_cnt == C_FLUSH1)      sel_code = SEL_FLUSH1;
    else if (col_cnt == C_FLUSH2) sel_code = SEL_FLUSH2;
    else                          sel_code = SEL_FLUSH3;
  end

  // Mirror without duplication: missing rows above/below fold about the edge row.
  always_comb begin
    col_pix[0] = pix_in;
    for (int k = 1; k < MASK_WIDTH; k++) col_pix[k] = lb_rd[k-1];
    if (row_cnt == R_BOT0)      col_pix[0] = lb_rd[1];
    else if (row_cnt == R_BOT1) col_pix[0] = lb_rd[3];
    else if (row_cnt == R_LAST) col_pix[0] = lb_rd[5];
    if (row_cnt == R_TOP0) begin
      col_pix[4] = lb_rd[1];
      col_pix[5] = lb_rd[0];
      col_pix[6] = pix_in;
    end else if (row_cnt == R_TOP1) begin
      col_pix[5] = lb_rd[2];
      col_pix[6] = lb_rd[1];
    end else if (row_cnt == R_TOP2) begin
      col_pix[6] = lb_rd[3];
    end
  end

  for (genvar k = 0; k < MASK_WIDTH - 1; k++) begin : g_lb
    logic [PIX_BIT-1:0] wr_data;
    if (k == 0) begin : g_head
      assign wr_data = col_pix[0];
    end else begin : g_tail
      assign wr_data = lb_rd[k-1];
    end
    line_buffer #(
      .DEPTH (IMG_WIDTH),
      .AW    (AW)
    ) u_lb (
      .clk     (clk),
      .we      (buf_we),
      .addr    (col_cnt[AW-1:0]),
      .wr_data (wr_data),
      .rd_data (lb_rd[k])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_valid                <= 1'b0;
      sel_left_col             <= 1'b0;
      center_valid             <= 1'b0;
      frame_done               <= 1'b0;
      sel_right_col            <= SEL_NORMAL;
      sngl_col_masked_pixs_out <= '0;
    end else begin
      col_valid     <= beat && show_col;
      sel_left_col  <= beat && (col_cnt == C_LEFT);
      center_valid  <= beat && show_col && (col_cnt >= C_LEFT);
      frame_done    <= frame_end;
      sel_right_col <= in_flush ? sel_code : SEL_NORMAL;
      if (beat) begin
        for (int s = 0; s < MASK_WIDTH; s++)
          sngl_col_masked_pixs_out[PIX_BIT*s +: PIX_BIT] <= in_flush ? '0 : col_pix[s];
      end
    end
  end

endmodule
